lsu: RTL

- Load/store unit directly downstream of the RV32I decoder.
- Consumes the decoder's `mem_wen`, `rf_wr_sel` and `mem_wr_sel` codes together with the ALU-computed address and the rs2 store data.
- Runs one data-memory transaction at a time over a valid/ready request and valid response bus.
- Returns byte-aligned, sign- or zero-extended load data (or a store acknowledge) to writeback. The pipeline stalls on `in_ready` / `out_valid`.

---
 rtl/lsu_if.sv | 40 ++++
 rtl/lsu.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Execute-side, writeback-side and data-memory bus signals of the load/store unit.
// The slave modport is the LSU view; master is the surrounding pipeline/memory view.
interface lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  mem_wen;
   logic                  rf_wr_sel;
   logic [2:0]            mem_wr_sel;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     rdata;
   logic                  err;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_we;
   logic [ADDR_W-1:0]     mem_req_addr;
   logic [DATA_W-1:0]     mem_req_wdata;
   logic [DATA_W/8-1:0]   mem_req_wstrb;
   logic                  mem_rsp_valid;
   logic [DATA_W-1:0]     mem_rsp_rdata;

   modport slave (
      input  in_valid, mem_wen, rf_wr_sel, mem_wr_sel, addr, wdata, out_ready,
             mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output in_ready, out_valid, rdata, err,
             mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb
   );

   modport master (
      output in_valid, mem_wen, rf_wr_sel, mem_wr_sel, addr, wdata, out_ready,
             mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  in_ready, out_valid, rdata, err,
             mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction at a time, lane placement for
// stores and byte-aligned sign/zero extension for loads.
module lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic   clk,
   input logic   rst,
   lsu_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t              state, state_nx;
   logic [1:0]          off_q;
   logic [1:0]          size_q;
   logic                sign_q;
   logic                we_q;
   logic                err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [3:0]          wstrb_q;

   logic                accept;
   logic                non_mem;
   logic                bad_op;
   logic [DATA_W-1:0]   lane_wdata;
   logic [3:0]          lane_wstrb;
   logic [DATA_W-1:0]   shifted;
   logic [DATA_W-1:0]   ld_data;

   assign accept = bus.in_valid && (state == IDLE);

   // Both-set is a decoder fault and wins over the "no memory op" reading.
   always_comb begin
      logic both;
      logic [2:0] code;
      code    = bus.mem_wr_sel;
      both    = bus.mem_wen && bus.rf_wr_sel;
      non_mem = !both && (!(bus.mem_wen || bus.rf_wr_sel) || code == 3'b111);
      bad_op  = both || code == 3'b011 || code == 3'b110 || (bus.mem_wen && code[2])
                || (code[1:0] == 2'b01 && bus.addr[0])
                || (code[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
   end

   always_comb begin
      lane_wdata = bus.wdata;
      lane_wstrb = 4'b1111;
      case (bus.mem_wr_sel[1:0])
         2'b00: begin
            lane_wdata = {4{bus.wdata[7:0]}};
            lane_wstrb = 4'b0001 << bus.addr[1:0];
         end
         2'b01: begin
            lane_wdata = {2{bus.wdata[15:0]}};
            lane_wstrb = 4'b0011 << bus.addr[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = bus.mem_rsp_rdata >> {off_q, 3'b000};
      ld_data = shifted;
      case (size_q)
         2'b00:   ld_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   ld_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = (non_mem || bad_op) ? DONE : REQ;
         REQ:  if (bus.mem_req_ready) state_nx = WAIT;
         WAIT: if (bus.mem_rsp_valid) state_nx = DONE;
         DONE: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q   <= '0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               off_q   <= bus.addr[1:0];
               size_q  <= bus.mem_wr_sel[1:0];
               sign_q  <= ~bus.mem_wr_sel[2];
               we_q    <= bus.mem_wen;
               addr_q  <= {bus.addr[ADDR_W-1:2], 2'b00};
               wdata_q <= lane_wdata;
               wstrb_q <= bus.mem_wen ? lane_wstrb : 4'b0000;
               rdata_q <= '0;
               err_q   <= !non_mem && bad_op;
            end
            WAIT: if (bus.mem_rsp_valid) rdata_q <= we_q ? '0 : ld_data;
            DONE: if (bus.out_ready) err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.in_ready      = (state == IDLE);
   assign bus.out_valid     = (state == DONE);
   assign bus.rdata         = rdata_q;
   assign bus.err           = err_q;
   assign bus.mem_req_valid = (state == REQ);
   assign bus.mem_req_we    = we_q;
   assign bus.mem_req_addr  = addr_q;
   assign bus.mem_req_wdata = wdata_q;
   assign bus.mem_req_wstrb = wstrb_q;
endmodule
